vga_fb_arbiter: RTL and testbench



---
 rtl/vga_fb_arbiter.sv | 127 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port 8x8-cell colour framebuffer between VGA scanout and a host port.
// Define FB_VBLANK_WRITE_EN to restrict host grants to vertical blanking (tear-free updates).
module vga_fb_arbiter #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned CELL_SHIFT = 3,
  parameter int unsigned CELLS_X    = 80,
  parameter int unsigned ADDR_W     = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        row_i,
  input  logic [9:0]        col_i,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [2:0]        host_wdata_i,
  output logic              host_ack_o,
  output logic [2:0]        host_rdata_o,
  output logic              host_rdata_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [2:0]        mem_wdata_o,
  input  logic [2:0]        mem_rdata_i,
  output logic [2:0]        pixel_rgb_o
);

  localparam int unsigned CNT_W = 10;
  localparam int unsigned RGB_W = 3;

  logic              active_c;
  logic              slot_c;
  logic              host_ok_c;
  logic              grant_c;
  logic [CNT_W-1:0]  row_cell_c;
  logic [CNT_W-1:0]  col_cell_c;
  logic [ADDR_W-1:0] scan_addr_c;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [RGB_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic              host_ack_q, host_ack_d;
  logic              rvalid_q, rvalid_d;
  logic              scan_d1_q, scan_d2_q;
  logic              active_d1_q, active_d2_q;
  logic [RGB_W-1:0]  cell_q, cell_d;
  logic [RGB_W-1:0]  pixel_q, pixel_d;

  assign active_c   = (col_i < CNT_W'(H_ACTIVE)) && (row_i < CNT_W'(V_ACTIVE));
  assign slot_c     = active_c && (col_i[CELL_SHIFT-1:0] == '0);
  assign row_cell_c = row_i >> CELL_SHIFT;
  assign col_cell_c = col_i >> CELL_SHIFT;

`ifdef FB_VBLANK_WRITE_EN
  assign host_ok_c = (row_i >= CNT_W'(V_ACTIVE));
`else
  assign host_ok_c = 1'b1;
`endif

  // A request seen in its own ack cycle is stale and must not be granted twice.
  assign grant_c = !slot_c && host_ok_c && host_req_i && !host_ack_q;

  // Cell address: row_cell * CELLS_X as a constant shift-add, plus column cell.
  always_comb begin
    scan_addr_c = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      if (CELLS_X[i]) scan_addr_c = scan_addr_c + (ADDR_W'(row_cell_c) << i);
    end
    scan_addr_c = scan_addr_c + ADDR_W'(col_cell_c);
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    host_ack_d  = grant_c;
    rvalid_d    = host_ack_q && !mem_we_q;
    if (slot_c) begin
      mem_addr_d = scan_addr_c;
    end else if (grant_c) begin
      mem_addr_d  = host_addr_i;
      mem_we_d    = host_we_i;
      mem_wdata_d = host_wdata_i;
    end
    // Fresh scan data bypasses into the pixel stage so latency stays at 3 cycles.
    cell_d  = scan_d2_q ? mem_rdata_i : cell_q;
    pixel_d = active_d2_q ? cell_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      host_ack_q  <= 1'b0;
      rvalid_q    <= 1'b0;
      scan_d1_q   <= 1'b0;
      scan_d2_q   <= 1'b0;
      active_d1_q <= 1'b0;
      active_d2_q <= 1'b0;
      cell_q      <= '0;
      pixel_q     <= '0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      host_ack_q  <= host_ack_d;
      rvalid_q    <= rvalid_d;
      scan_d1_q   <= slot_c;
      scan_d2_q   <= scan_d1_q;
      active_d1_q <= active_c;
      active_d2_q <= active_d1_q;
      cell_q      <= cell_d;
      pixel_q     <= pixel_d;
    end
  end

  assign mem_addr_o         = mem_addr_q;
  assign mem_we_o           = mem_we_q;
  assign mem_wdata_o        = mem_wdata_q;
  assign host_ack_o         = host_ack_q;
  assign host_rdata_valid_o = rvalid_q;
  // Read data arrives from the RAM in the valid cycle itself.
  assign host_rdata_o       = rvalid_q ? mem_rdata_i : '0;
  assign pixel_rgb_o        = pixel_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed scenarios plus randomized scan/host traffic
// checked against a framebuffer-level reference model.
module tb_vga_fb_arbiter;

  localparam int unsigned ADDR_W   = 13;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int CELLS_X  = 80;
`ifdef FB_VBLANK_WRITE_EN
  localparam int RST_ROW = 490;
`else
  localparam int RST_ROW = 5;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        row, col;
  logic              host_req, host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [2:0]        host_wdata;
  logic              host_ack, host_rdata_valid;
  logic [2:0]        host_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [2:0]        mem_wdata;
  logic [2:0]        mem_rdata = 3'b000;
  logic [2:0]        pixel_rgb;

  vga_fb_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .row_i              (row),
    .col_i              (col),
    .host_req_i         (host_req),
    .host_we_i          (host_we),
    .host_addr_i        (host_addr),
    .host_wdata_i       (host_wdata),
    .host_ack_o         (host_ack),
    .host_rdata_o       (host_rdata),
    .host_rdata_valid_o (host_rdata_valid),
    .mem_addr_o         (mem_addr),
    .mem_we_o           (mem_we),
    .mem_wdata_o        (mem_wdata),
    .mem_rdata_i        (mem_rdata),
    .pixel_rgb_o        (pixel_rgb)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle registered read
  logic [2:0] ram [0:8191] = '{default: 3'b000};
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model state
  logic [2:0] ref_fb [0:8191] = '{default: 3'b000};
  int   n_chk = 0;
  int   n_fail = 0;
  bit   h_req, h_we;
  int   h_addr, h_wd;
  bit   ack_now, e_ack, e_we;
  int   e_addr, e_wd, last_cell;
  bit   rv_pipe [0:1];
  int   rd_pipe [0:1];
  int   pix_pipe [0:2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ack_now = 0; e_ack = 0; e_we = 0; e_addr = 0; e_wd = 0; last_cell = 0;
    rv_pipe[0] = 0; rv_pipe[1] = 0; rd_pipe[0] = 0; rd_pipe[1] = 0;
    for (int i = 0; i < 3; i++) pix_pipe[i] = 0;
  endtask

  task automatic host_start(input bit we, input int addr, input int wd);
    h_req = 1; h_we = we; h_addr = addr; h_wd = wd;
  endtask

  // Drive one cycle at (r,c), predict its effects, then advance and compare.
  task automatic step(input int r, input int c);
    bit act, slot, grant;
    if (h_req && ack_now) h_req = 0;
    row = 10'(r); col = 10'(c);
    host_req = h_req; host_we = h_we; host_addr = ADDR_W'(h_addr); host_wdata = 3'(h_wd);
    act   = (c < H_ACTIVE) && (r < V_ACTIVE);
    slot  = act && (c % 8 == 0);
    grant = !slot && h_req && !ack_now;
`ifdef FB_VBLANK_WRITE_EN
    if (r < V_ACTIVE) grant = 0;
`endif
    e_ack = grant;
    e_we  = grant && h_we;
    rv_pipe[0] = grant && !h_we;
    rd_pipe[0] = 0;
    if (slot) begin
      e_addr    = (r / 8) * CELLS_X + c / 8;
      last_cell = int'(ref_fb[e_addr]);
    end else if (grant) begin
      e_addr = h_addr;
      e_wd   = h_wd;
      if (h_we) ref_fb[h_addr] = 3'(h_wd);
      else rd_pipe[0] = int'(ref_fb[h_addr]);
    end
    pix_pipe[0] = act ? last_cell : 0;
    @(posedge clk);
    #1;
    check("host_ack", 32'(host_ack), 32'(e_ack));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_we) check("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    check("rdata_valid", 32'(host_rdata_valid), 32'(rv_pipe[1]));
    if (rv_pipe[1]) check("host_rdata", 32'(host_rdata), 32'(rd_pipe[1]));
    check("pixel_rgb", 32'(pixel_rgb), 32'(pix_pipe[2]));
    ack_now    = e_ack;
    rv_pipe[1] = rv_pipe[0]; rd_pipe[1] = rd_pipe[0];
    pix_pipe[2] = pix_pipe[1]; pix_pipe[1] = pix_pipe[0];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 32'(host_ack), 32'd0);
    check({tag, "_rvalid"}, 32'(host_rdata_valid), 32'd0);
    check({tag, "_rdata"}, 32'(host_rdata), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_pixel"}, 32'(pixel_rgb), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    bit got_ack;
    h_req = 0; h_we = 0; h_addr = 0; h_wd = 0;
    rst = 1'b1; row = '0; col = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Preload cells 0 and 1 during blanking
    bc = 0;
    host_start(1, 0, 3'b100);
    repeat (3) begin step(500, bc); bc++; end
    host_start(1, 1, 3'b010);
    repeat (3) begin step(500, bc); bc++; end

    // Scanout timing on row 0
    for (int c = 0; c < 20; c++) begin
      step(0, c);
      if (c == 0) check("scan_addr_c1", 32'(mem_addr), 32'd0);
      if (c == 8) check("scan_addr_c9", 32'(mem_addr), 32'd1);
      if (c + 1 >= 3 && c + 1 <= 10) check("pix_cell0", 32'(pixel_rgb), 32'h4);
      if (c + 1 >= 11 && c + 1 <= 18) check("pix_cell1", 32'(pixel_rgb), 32'h2);
    end

    // Address math at the bottom-right cell
    for (int c = 632; c <= 640; c++) begin
      step(479, c);
      if (c == 632) check("addr_4799", 32'(mem_addr), 32'd4799);
    end

`ifndef FB_VBLANK_WRITE_EN
    // Host write colliding with a scan slot
    host_start(1, 10, 3'b111);
    for (int c = 16; c < 24; c++) begin
      step(5, c);
      if (c == 16) begin
        check("contend_scan_first", 32'(mem_addr), 32'd2);
        check("contend_no_ack", 32'(host_ack), 32'd0);
      end
      if (c == 17) begin
        check("contend_ack", 32'(host_ack), 32'd1);
        check("contend_we", 32'(mem_we), 32'd1);
        check("contend_addr", 32'(mem_addr), 32'd10);
      end
      if (c >= 18) check("contend_no_rewrite", 32'(mem_we), 32'd0);
    end
`else
    // Host write must wait for vertical blank
    host_start(1, 10, 3'b111);
    for (int c = 16; c < 24; c++) begin
      step(100, c);
      check("vb_hold_r100", 32'(host_ack), 32'd0);
    end
    step(479, 700);
    check("vb_hold_r479", 32'(host_ack), 32'd0);
    step(480, 0);
    check("vb_ack_r480", 32'(host_ack), 32'd1);
    step(480, 1);
`endif

    // Host read during blanking
    host_start(0, 10, 3'b000);
    step(500, 100);
    check("rd_ack", 32'(host_ack), 32'd1);
    check("rd_pix0_a", 32'(pixel_rgb), 32'd0);
    step(500, 101);
    check("rd_valid", 32'(host_rdata_valid), 32'd1);
    check("rd_data", 32'(host_rdata), 32'h7);
    check("rd_pix0_b", 32'(pixel_rgb), 32'd0);
    step(500, 102);

    // Reset while a host request is pending at a scan slot
    host_start(1, 20, 3'b101);
    row = 10'(RST_ROW); col = 10'd24;
    host_req = 1; host_we = 1; host_addr = ADDR_W'(20); host_wdata = 3'b101;
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    got_ack = 0;
    step(RST_ROW, 24);
    if (host_ack) got_ack = 1;
    step(RST_ROW, 25);
    if (host_ack) got_ack = 1;
    check("ack_after_reset", 32'(got_ack), 32'd1);
    step(RST_ROW, 26);

    // Randomized scan segments with concurrent host traffic
    for (int s = 0; s < 250; s++) begin
      int r, c0, len, a;
      r   = int'($urandom_range(0, 524));
      c0  = 8 * int'($urandom_range(0, 99));
      len = int'($urandom_range(8, 48));
      if (c0 + len > 800) len = 800 - c0;
      for (int k = 0; k < len; k++) begin
        if (!h_req && $urandom_range(0, 3) == 0) begin
          a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8191))
                                          : int'($urandom_range(0, 4799));
          host_start(1'($urandom_range(0, 1)), a, int'($urandom_range(0, 7)));
        end
        step(r, c0 + k);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
